wr_txn_table: RTL and testbench
===============================

Name: wr_txn_table

Overview:
State-holding stage paired with wr_txn_manager. It registers the head/tail (per-ID queue) and linked-data (per-transaction) tables, ages every live transaction budget counter, and derives the lookup signals the manager consumes: free slots, ID match, response index and full. Manager next-state arrays come in; registered arrays and lookups go back out.

Parameters:
MaxWrTxns, 4, linked-data entries (outstanding AW transactions); power of two, at least 2
HtCapacity, 4, head/tail entries (distinct outstanding IDs); power of two, at least 2
IdWidth, 4, AXI ID width
LenWidth, 8, AXI burst length width
CntWidth, 10, budget counter width
PrescalerDiv, 1, clock cycles per budget tick; at least 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
head_tail_d_i  in  HtCapacity x ht_entry_t  manager next-state head/tail table
linked_data_d_i  in  MaxWrTxns x ld_entry_t  manager next-state linked-data table
head_tail_q_o  out  HtCapacity x ht_entry_t  registered head/tail table
linked_data_q_o  out  MaxWrTxns x ld_entry_t  registered linked-data table
match_in_id_i  in  IdWidth  AW ID being enqueued
match_in_id_valid_i  in  1  qualifies match_in_id_i
b_id_i  in  IdWidth  ID of the current B response
no_in_id_match_o  out  1  no live head/tail entry holds match_in_id_i
match_in_idx_o  out  log2(HtCapacity)  head/tail index matching match_in_id_i
id_exists_o  out  1  live head/tail entry holds b_id_i
rsp_idx_o  out  log2(HtCapacity)  head/tail index matching b_id_i
head_tail_free_idx_o  out  log2(HtCapacity)  lowest free head/tail index
linked_data_free_idx_o  out  log2(MaxWrTxns)  lowest free linked-data index
full_o  out  1  enqueue not possible
occupancy_o  out  log2(MaxWrTxns)+1  live linked-data entries

Behaviour:
- Reset (async on rst_ni low): every entry free=1 with all other fields 0. Prescaler is 0. Outputs after reset: full_o=0, no_in_id_match_o=1, id_exists_o=0, all indices 0, occupancy_o=0.
- Table update, each clk_i edge: head_tail_q <= head_tail_d_i, and linked_data_q <= linked_data_d_i. The only exception is the counter field, below.
- Prescaler: free-running count from 0 to PrescalerDiv-1. tick=1 when count equals PrescalerDiv-1, then the count wraps to 0. With PrescalerDiv=1, tick=1 every cycle.
- Counter aging, per entry i: decrement linked_data_d_i[i].counter by 1 when all of these hold: tick; linked_data_q[i].free=0; linked_data_d_i[i].free=0; counter>0.
  - A slot allocated this cycle (q free=1) loads its budget undecremented.
  - A slot freed this cycle loads the manager value.
  - Counter saturates at 0 and never wraps. The manager detects timeout at 0.
- Lookups: combinational from the _q registers only, zero latency.
  - Free finders: lowest free index. Output is 0 when none is free.
  - ID matches: lowest matching live entry (free=0, id equal).
    - match_in_idx_o and no_in_id_match_o are valid only when match_in_id_valid_i=1; otherwise no_in_id_match_o=1 and match_in_idx_o=0.
    - rsp_idx_o is 0 when id_exists_o=0.
- full_o=1 when either holds:
  - no free linked-data entry;
  - match_in_id_valid_i=1, no free head/tail entry and no_in_id_match_o=1.
- Simultaneous dequeue and enqueue: full_o reflects _q state only, so a slot freed this cycle is not reusable until the next cycle (conservative, no combinational loop through the manager).
- occupancy_o: popcount of linked-data free=0.
- Flush (manager writes all entries free): tables clear on the next edge. The prescaler is not reset.
- Invariants, asserted in simulation:
  - Live IDs are unique in head/tail.
  - occupancy_o ≤ MaxWrTxns.

Decomposition:
- Package wr_txn_pkg holds ht_entry_t {id, head, tail, free} and ld_entry_t {metadata {id, len}, counter, next, free}. The types are parameterized through localparam widths derived from the block parameters, plus the index width helpers.
- One sub-module, wr_txn_free_finder: parameterized lowest-set-bit finder over a free-flag vector, returning index and any_free. Instantiated twice.

Test Plan:
- Reset with PrescalerDiv=1 → free idx 0/0, full_o=0, occupancy_o=0, no_in_id_match_o=1.
- Write ld[0] live with counter=5 and hold the manager inputs equal to q for 5 cycles → counter reads 5, 4, 3, 2, 1, 0, then stays at 0.
- PrescalerDiv=4, ld[1] counter=3 → decrements once every 4 cycles, reaching 0 after 12 cycles.
- Fill all 4 linked-data entries with IDs 1, 1, 2, 3 → full_o=1, occupancy_o=4. Then match_in_id=1 gives match_in_idx_o = index of ID 1, and b_id=3 gives id_exists_o=1 with the correct rsp_idx_o.
- With the table full, free ld[2] and present a new allocation the same cycle → full_o=1 that cycle, full_o=0 and linked_data_free_idx_o=2 the next cycle.
- rst_ni low mid-aging while counters are live → all entries free immediately (asynchronously), counters 0, full_o=0.

Source files
------------

// File: rtl/wr_txn_pkg.sv
// Shared types for the write-transaction table: head/tail (per-ID queue) and
// linked-data (per-transaction) entries, plus the width helpers they depend on.
package wr_txn_pkg;

  localparam int unsigned TxnCount = 4;
  localparam int unsigned HtCount  = 4;
  localparam int unsigned IdW      = 4;
  localparam int unsigned LenW     = 8;
  localparam int unsigned CntW     = 10;
  localparam int unsigned LdIdxW   = $clog2(TxnCount);
  localparam int unsigned HtIdxW   = $clog2(HtCount);

  typedef struct packed {
    logic [IdW-1:0]  id;
    logic [LenW-1:0] len;
  } metadata_t;

  typedef struct packed {
    logic [IdW-1:0]    id;
    logic [LdIdxW-1:0] head;
    logic [LdIdxW-1:0] tail;
    logic              free;
  } ht_entry_t;

  typedef struct packed {
    metadata_t         metadata;
    logic [CntW-1:0]   counter;
    logic [LdIdxW-1:0] next;
    logic              free;
  } ld_entry_t;

  localparam ht_entry_t HtFree = '{id: '0, head: '0, tail: '0, free: 1'b1};
  localparam ld_entry_t LdFree = '{metadata: '0, counter: '0, next: '0, free: 1'b1};

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wr_txn_free_finder.sv
// Lowest-set-bit finder over a free-flag vector; index is 0 when nothing is set.
module wr_txn_free_finder #(
  parameter  int unsigned N = 4,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] free_i,
  output logic [W-1:0] idx_o,
  output logic         any_free_o
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx_o      = '0;
    any_free_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        idx_o      = W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wr_txn_table.sv
// Registered head/tail and linked-data tables for the write-transaction manager,
// with budget-counter aging and the zero-latency lookups the manager consumes.
module wr_txn_table
  import wr_txn_pkg::*;
#(
  parameter  int unsigned MaxWrTxns    = TxnCount,
  parameter  int unsigned HtCapacity   = HtCount,
  parameter  int unsigned IdWidth      = IdW,
  parameter  int unsigned LenWidth     = LenW,
  parameter  int unsigned CntWidth     = CntW,
  parameter  int unsigned PrescalerDiv = 1,
  localparam int unsigned HtIdxWidth   = $clog2(HtCapacity),
  localparam int unsigned LdIdxWidth   = $clog2(MaxWrTxns),
  localparam int unsigned OccWidth     = $clog2(MaxWrTxns) + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  ht_entry_t [HtCapacity-1:0]       head_tail_d_i,
  input  ld_entry_t [MaxWrTxns-1:0]        linked_data_d_i,
  output ht_entry_t [HtCapacity-1:0]       head_tail_q_o,
  output ld_entry_t [MaxWrTxns-1:0]        linked_data_q_o,
  input  logic [IdWidth-1:0]               match_in_id_i,
  input  logic                             match_in_id_valid_i,
  input  logic [IdWidth-1:0]               b_id_i,
  output logic                             no_in_id_match_o,
  output logic [HtIdxWidth-1:0]            match_in_idx_o,
  output logic                             id_exists_o,
  output logic [HtIdxWidth-1:0]            rsp_idx_o,
  output logic [HtIdxWidth-1:0]            head_tail_free_idx_o,
  output logic [LdIdxWidth-1:0]            linked_data_free_idx_o,
  output logic                             full_o,
  output logic [OccWidth-1:0]              occupancy_o
);

  localparam int unsigned PrescW = idx_width(PrescalerDiv);

  // Entry types come from the package, so the sizing parameters must agree with it.
  if (MaxWrTxns != TxnCount || HtCapacity != HtCount || IdWidth != IdW ||
      LenWidth != LenW || CntWidth != CntW || PrescalerDiv < 1) begin : g_param_check
    $error("wr_txn_table parameters disagree with wr_txn_pkg");
  end

  logic [PrescW-1:0]            r_presc;
  logic                         w_tick;
  ht_entry_t [HtCapacity-1:0]   r_ht;
  ld_entry_t [MaxWrTxns-1:0]    r_ld;
  ld_entry_t [MaxWrTxns-1:0]    w_ld_next;
  logic [HtCapacity-1:0]        w_ht_free;
  logic [MaxWrTxns-1:0]         w_ld_free;
  logic                         w_ht_any_free;
  logic                         w_ld_any_free;
  logic                         w_in_hit;
  logic [HtIdxWidth-1:0]        w_in_idx;
  logic                         w_rsp_hit;
  logic [HtIdxWidth-1:0]        w_rsp_idx;
  logic [OccWidth-1:0]          w_occ;
  logic                         w_ids_unique;

  assign w_tick = (r_presc == PrescW'(PrescalerDiv - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PrescW'(1);
    end
  end

  // Age only slots live both before and after this edge; fresh and freed slots
  // take the manager value as-is, and zero never wraps.
  always_comb begin
    w_ld_next = linked_data_d_i;
    for (int i = 0; i < MaxWrTxns; i++) begin
      if (w_tick && !r_ld[i].free && !linked_data_d_i[i].free &&
          linked_data_d_i[i].counter != '0) begin
        w_ld_next[i].counter = linked_data_d_i[i].counter - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < HtCapacity; i++) r_ht[i] <= HtFree;
      for (int i = 0; i < MaxWrTxns; i++) r_ld[i] <= LdFree;
    end else begin
      r_ht <= head_tail_d_i;
      r_ld <= w_ld_next;
    end
  end

  always_comb begin
    w_ht_free = '0;
    w_ld_free = '0;
    for (int i = 0; i < HtCapacity; i++) w_ht_free[i] = r_ht[i].free;
    for (int i = 0; i < MaxWrTxns; i++) w_ld_free[i] = r_ld[i].free;
  end

  wr_txn_free_finder #(.N(HtCapacity)) u_ht_free (
    .free_i     (w_ht_free),
    .idx_o      (head_tail_free_idx_o),
    .any_free_o (w_ht_any_free)
  );

  wr_txn_free_finder #(.N(MaxWrTxns)) u_ld_free (
    .free_i     (w_ld_free),
    .idx_o      (linked_data_free_idx_o),
    .any_free_o (w_ld_any_free)
  );

  always_comb begin
    w_in_hit  = 1'b0;
    w_in_idx  = '0;
    w_rsp_hit = 1'b0;
    w_rsp_idx = '0;
    for (int i = HtCapacity - 1; i >= 0; i--) begin
      if (!r_ht[i].free && match_in_id_valid_i && r_ht[i].id == match_in_id_i) begin
        w_in_hit = 1'b1;
        w_in_idx = HtIdxWidth'(i);
      end
      if (!r_ht[i].free && r_ht[i].id == b_id_i) begin
        w_rsp_hit = 1'b1;
        w_rsp_idx = HtIdxWidth'(i);
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < MaxWrTxns; i++) begin
      if (!r_ld[i].free) w_occ = w_occ + OccWidth'(1);
    end
  end

  always_comb begin
    w_ids_unique = 1'b1;
    for (int i = 0; i < HtCapacity; i++) begin
      for (int j = i + 1; j < HtCapacity; j++) begin
        if (!r_ht[i].free && !r_ht[j].free && r_ht[i].id == r_ht[j].id) w_ids_unique = 1'b0;
      end
    end
  end

  a_ids_unique: assert property (@(posedge clk_i) disable iff (!rst_ni) w_ids_unique);
  a_occ_bound:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 w_occ <= OccWidth'(MaxWrTxns));

  assign head_tail_q_o    = r_ht;
  assign linked_data_q_o  = r_ld;
  assign no_in_id_match_o = !w_in_hit;
  assign match_in_idx_o   = w_in_idx;
  assign id_exists_o      = w_rsp_hit;
  assign rsp_idx_o        = w_rsp_idx;
  assign occupancy_o      = w_occ;
  // Decided from registered state only, so a slot freed this cycle is reusable next cycle.
  assign full_o = !w_ld_any_free ||
                  (match_in_id_valid_i && !w_ht_any_free && !w_in_hit);

endmodule

// File: tb/tb_wr_txn_table.sv
// Directed bench for wr_txn_table: one instance ticking every cycle, one ticking every 4.
module tb_wr_txn_table;
  import wr_txn_pkg::*;

  logic clk;
  logic rst_n;

  ht_entry_t [3:0] ht_d, ht_q1, ht_q4, ht_idle;
  ld_entry_t [3:0] ld_d, ld_q1, ld_d4, ld_q4;
  logic [3:0] match_id, b_id;
  logic       match_valid;

  logic       no_match1, id_exists1, full1;
  logic [1:0] match_idx1, rsp_idx1, ht_free1, ld_free1;
  logic [2:0] occ1;
  logic       no_match4, id_exists4, full4;
  logic [1:0] match_idx4, rsp_idx4, ht_free4, ld_free4;
  logic [2:0] occ4;

  int n_checks = 0;
  int n_errors = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wr_txn_table #(.PrescalerDiv(1)) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .head_tail_d_i          (ht_d),
    .linked_data_d_i        (ld_d),
    .head_tail_q_o          (ht_q1),
    .linked_data_q_o        (ld_q1),
    .match_in_id_i          (match_id),
    .match_in_id_valid_i    (match_valid),
    .b_id_i                 (b_id),
    .no_in_id_match_o       (no_match1),
    .match_in_idx_o         (match_idx1),
    .id_exists_o            (id_exists1),
    .rsp_idx_o              (rsp_idx1),
    .head_tail_free_idx_o   (ht_free1),
    .linked_data_free_idx_o (ld_free1),
    .full_o                 (full1),
    .occupancy_o            (occ1)
  );

  wr_txn_table #(.PrescalerDiv(4)) dut4 (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .head_tail_d_i          (ht_idle),
    .linked_data_d_i        (ld_d4),
    .head_tail_q_o          (ht_q4),
    .linked_data_q_o        (ld_q4),
    .match_in_id_i          (match_id),
    .match_in_id_valid_i    (match_valid),
    .b_id_i                 (b_id),
    .no_in_id_match_o       (no_match4),
    .match_in_idx_o         (match_idx4),
    .id_exists_o            (id_exists4),
    .rsp_idx_o              (rsp_idx4),
    .head_tail_free_idx_o   (ht_free4),
    .linked_data_free_idx_o (ld_free4),
    .full_o                 (full4),
    .occupancy_o            (occ4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic ld_entry_t mk_ld(input logic [3:0] id, input logic [9:0] cnt);
    ld_entry_t e;
    e = LdFree;
    e.metadata.id = id;
    e.metadata.len = 8'd3;
    e.counter = cnt;
    e.free = 1'b0;
    return e;
  endfunction

  function automatic ht_entry_t mk_ht(input logic [3:0] id, input logic [1:0] idx);
    ht_entry_t e;
    e.id = id;
    e.head = idx;
    e.tail = idx;
    e.free = 1'b0;
    return e;
  endfunction

  // Manager that keeps its next-state equal to the registered tables.
  task automatic hold();
    ht_d  = ht_q1;
    ld_d  = ld_q1;
    ld_d4 = ld_q4;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    match_id = '0;
    match_valid = 1'b0;
    b_id = '0;
    for (int i = 0; i < 4; i++) begin
      ht_d[i] = HtFree;
      ht_idle[i] = HtFree;
      ld_d[i] = LdFree;
      ld_d4[i] = LdFree;
    end

    // Reset state
    @(negedge clk);
    #1;
    check("rst_ht_free_idx", ht_free1, 0);
    check("rst_ld_free_idx", ld_free1, 0);
    check("rst_full", full1, 0);
    check("rst_occ", occ1, 0);
    check("rst_no_match", no_match1, 1);
    check("rst_id_exists", id_exists1, 0);
    check("rst_ld0_free", ld_q1[0].free, 1);
    check("rst_full_div4", full4, 0);

    // Divide-by-4 aging: load counter 3 on first edge after reset release
    ld_d4[1] = mk_ld(4'd2, 10'd3);
    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cycle();
      check($sformatf("div4_cnt_k%0d", k), ld_q4[1].counter, (k >= 12) ? 0 : 3 - k / 4);
      hold();
    end

    // Divide-by-1 aging from 5 with saturation at 0
    ld_d[0] = mk_ld(4'd1, 10'd5);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check($sformatf("div1_cnt_k%0d", k), ld_q1[0].counter, (k <= 6) ? 6 - k : 0);
      hold();
    end
    check("age_occ", occ1, 1);
    check("age_ld_free_idx", ld_free1, 1);

    // Fill: IDs 1,1,2,3 in linked data; 1,2,3 in head/tail
    ht_d[0] = mk_ht(4'd1, 2'd0);
    ht_d[1] = mk_ht(4'd2, 2'd2);
    ht_d[2] = mk_ht(4'd3, 2'd3);
    ld_d[0] = mk_ld(4'd1, 10'd100);
    ld_d[1] = mk_ld(4'd1, 10'd100);
    ld_d[2] = mk_ld(4'd2, 10'd100);
    ld_d[3] = mk_ld(4'd3, 10'd100);
    cycle();
    match_id = 4'd1;
    match_valid = 1'b1;
    b_id = 4'd3;
    #1;
    check("fill_full", full1, 1);
    check("fill_occ", occ1, 4);
    check("fill_ld_free_idx", ld_free1, 0);
    check("fill_ht_free_idx", ht_free1, 3);
    check("fill_match_idx", match_idx1, 0);
    check("fill_no_match", no_match1, 0);
    check("fill_id_exists", id_exists1, 1);
    check("fill_rsp_idx", rsp_idx1, 2);
    match_id = 4'd5;
    b_id = 4'd5;
    #1;
    check("miss_no_match", no_match1, 1);
    check("miss_match_idx", match_idx1, 0);
    check("miss_id_exists", id_exists1, 0);
    check("miss_rsp_idx", rsp_idx1, 0);
    check("miss_full", full1, 1);

    // Free ld[2] while a new allocation is presented
    hold();
    ld_d[2].free = 1'b1;
    match_id = 4'd4;
    #1;
    check("deq_same_cycle_full", full1, 1);
    cycle();
    #1;
    check("deq_next_full", full1, 0);
    check("deq_next_ld_free_idx", ld_free1, 2);
    check("deq_next_occ", occ1, 3);

    // Head/tail full: only a new ID is blocked
    hold();
    ht_d[3] = mk_ht(4'd4, 2'd1);
    cycle();
    hold();
    match_id = 4'd5;
    #1;
    check("htfull_new_full", full1, 1);
    check("htfull_ht_free_idx", ht_free1, 0);
    match_id = 4'd2;
    #1;
    check("htfull_hit_full", full1, 0);
    check("htfull_hit_idx", match_idx1, 1);
    match_valid = 1'b0;
    #1;
    check("novalid_no_match", no_match1, 1);
    check("novalid_match_idx", match_idx1, 0);
    check("novalid_full", full1, 0);

    // Asynchronous reset in the middle of aging
    cycle();
    hold();
    cycle();
    hold();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("arst_ld%0d_free", i), ld_q1[i].free, 1);
      check($sformatf("arst_ld%0d_cnt", i), ld_q1[i].counter, 0);
      check($sformatf("arst_ht%0d_free", i), ht_q1[i].free, 1);
    end
    check("arst_full", full1, 0);
    check("arst_occ", occ1, 0);
    check("arst_div4_ld1_free", ld_q4[1].free, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
